// File: rtl/gpr_wb.sv
// rtl/gpr_wb.sv - register writeback stage with a single result slot and a busy scoreboard
// The LSU channel has fixed priority over the ALU channel. Writes to x0 are accepted and dropped.
module gpr_wb #(
  parameter int NR_REG = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  output logic        iss_stall,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        idle,
  output logic        wb_err
);

  // Busy bits for x0 and for indices beyond NR_REG are masked to 0.
  localparam logic [31:0] REG_MASK = (NR_REG >= 32) ? 32'hFFFF_FFFE
                                   : (((32'd1 << NR_REG) - 32'd1) & 32'hFFFF_FFFE);

  logic [31:0] busy;
  logic [31:0] busy_nxt;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_q;

  logic        xfer;
  logic [4:0]  xfer_rd;
  logic [31:0] xfer_data;
  logic        xfer_wr;
  logic        set_en;

  assign lsu_ready = 1'b1;
  assign alu_ready = !lsu_valid;

  always_comb begin
    xfer      = lsu_valid | alu_valid;
    xfer_rd   = lsu_valid ? lsu_rd : alu_rd;
    xfer_data = lsu_valid ? lsu_data : alu_data;
    xfer_wr   = xfer && (xfer_rd != 5'd0);
  end

  assign iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]);
  assign set_en    = iss_valid & !iss_stall & (iss_rd != 5'd0);

  // Clear first, then set, so a same-edge claim of the retiring register wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_rd] = 1'b0;
    if (set_en)   busy_nxt[iss_rd] = 1'b1;
    busy_nxt = busy_nxt & REG_MASK;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
      busy     <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      wb_valid <= xfer_wr;
      if (xfer_wr) begin
        wb_rd   <= xfer_rd;
        wb_data <= xfer_data;
      end
      busy <= busy_nxt;
      if (xfer_wr && !busy[xfer_rd]) err_q <= 1'b1;
    end
  end

  assign gpr_wen   = wb_valid;
  assign gpr_waddr = wb_rd;
  assign gpr_wdata = wb_data;
  assign idle      = !wb_valid & ~|busy;
  assign wb_err    = err_q;

endmodule

// File: tb/tb_gpr_wb.sv
// tb/tb_gpr_wb.sv - directed bench for gpr_wb
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_gpr_wb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
  logic        alu_ready, lsu_ready, iss_stall, gpr_wen, idle, wb_err;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, iss_rd = '0, iss_rs1 = '0, iss_rs2 = '0;
  logic [4:0]  gpr_waddr;
  logic [31:0] alu_data = '0, lsu_data = '0, gpr_wdata;
  int checks = 0;
  int errors = 0;

  gpr_wb #(.NR_REG(32)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall), .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .idle(idle), .wb_err(wb_err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 0; lsu_valid = 0; iss_valid = 0;
    alu_rd = 0; lsu_rd = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic claim(input logic [4:0] rd);
    iss_valid = 1; iss_rd = rd; iss_rs1 = 0; iss_rs2 = 0;
    tick();
    iss_valid = 0; iss_rd = 0;
  endtask

  // Probe a register through the stall output without claiming anything.
  task automatic query(input logic [4:0] rs);
    iss_valid = 1; iss_rd = 0; iss_rs1 = rs; iss_rs2 = 0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3 reset = 1'b0;
    tick(); tick();
    iss_valid = 1; iss_rs1 = 5; lsu_valid = 1; #1;
    checks++; if (gpr_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %0b exp 0", gpr_wen); end
    checks++; if (gpr_waddr !== 5'd0) begin errors++; $display("FAIL rst_waddr: got %0d exp 0", gpr_waddr); end
    checks++; if (gpr_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h exp 0", gpr_wdata); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %0b exp 1", idle); end
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL rst_lsu_ready: got %0b exp 1", lsu_ready); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready_lsu1: got %0b exp 0", alu_ready); end
    lsu_valid = 0; #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rst_alu_ready_lsu0: got %0b exp 1", alu_ready); end
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b exp 0", iss_stall); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b exp 0", wb_err); end
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_claim_write;
    claim(5);
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL claim_idle: got %0b exp 0", idle); end
    query(5);
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL claim_busy5: got %0b exp 1", iss_stall); end
    iss_valid = 0;
    tick();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    checks++; if (gpr_wen !== 1'b1) begin errors++; $display("FAIL claim_wen: got %0b exp 1", gpr_wen); end
    checks++; if (gpr_waddr !== 5'd5) begin errors++; $display("FAIL claim_waddr: got %0d exp 5", gpr_waddr); end
    checks++; if (gpr_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL claim_wdata: got %h exp deadbeef", gpr_wdata); end
    tick();
    checks++; if (gpr_wen !== 1'b0) begin errors++; $display("FAIL claim_wen_after: got %0b exp 0", gpr_wen); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL claim_idle_after: got %0b exp 1", idle); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL claim_err: got %0b exp 0", wb_err); end
  endtask

  task automatic test_hazard;
    claim(7);
    query(7);
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL haz_stall: got %0b exp 1", iss_stall); end
    query(0);
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL haz_x0_nostall: got %0b exp 0", iss_stall); end
    iss_valid = 0; iss_rs1 = 7; #1;
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL haz_novalid: got %0b exp 0", iss_stall); end
    alu_valid = 1; alu_rd = 7; alu_data = 32'h0000_0077;
    tick();
    alu_valid = 0;
    query(7);
    checks++; if (gpr_wen !== 1'b1) begin errors++; $display("FAIL haz_wen: got %0b exp 1", gpr_wen); end
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL haz_stall_wen: got %0b exp 1", iss_stall); end
    tick();
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL haz_stall_release: got %0b exp 0", iss_stall); end
    iss_valid = 0;
  endtask

  task automatic test_contention;
    claim(3);
    claim(4);
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22; #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL cont_alu_ready: got %0b exp 0", alu_ready); end
    tick();
    lsu_valid = 0;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd4 || gpr_wdata !== 32'h22)
      begin errors++; $display("FAIL cont_first: got wen=%0b rd=%0d d=%h exp 1 4 22", gpr_wen, gpr_waddr, gpr_wdata); end
    tick();
    alu_valid = 0;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd3 || gpr_wdata !== 32'h11)
      begin errors++; $display("FAIL cont_second: got wen=%0b rd=%0d d=%h exp 1 3 11", gpr_wen, gpr_waddr, gpr_wdata); end
    tick();
    checks++; if (gpr_wen !== 1'b0 || idle !== 1'b1 || wb_err !== 1'b0)
      begin errors++; $display("FAIL cont_end: got wen=%0b idle=%0b err=%0b exp 0 1 0", gpr_wen, idle, wb_err); end
  endtask

  task automatic test_err_x0;
    do_reset();
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hAAAA_0000;
    tick();
    lsu_valid = 0;
    checks++; if (gpr_wen !== 1'b0 || wb_err !== 1'b0 || idle !== 1'b1)
      begin errors++; $display("FAIL x0_noop: got wen=%0b err=%0b idle=%0b exp 0 0 1", gpr_wen, wb_err, idle); end
    lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hC0FFEE12;
    tick();
    lsu_valid = 0;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd12 || gpr_wdata !== 32'hC0FFEE12)
      begin errors++; $display("FAIL err_write: got wen=%0b rd=%0d d=%h exp 1 12 c0ffee12", gpr_wen, gpr_waddr, gpr_wdata); end
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b exp 1", wb_err); end
    lsu_valid = 1; lsu_rd = 0;
    tick();
    lsu_valid = 0;
    checks++; if (gpr_wen !== 1'b0 || wb_err !== 1'b1)
      begin errors++; $display("FAIL err_x0_sticky: got wen=%0b err=%0b exp 0 1", gpr_wen, wb_err); end
    tick();
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_held: got %0b exp 1", wb_err); end
  endtask

  task automatic test_same_edge;
    do_reset();
    // Unclaimed result for 9 leaves busy[9]=0 in the write cycle, so a claim of 9 is not stalled.
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    tick();
    alu_valid = 0;
    iss_valid = 1; iss_rd = 9; iss_rs1 = 0; iss_rs2 = 0; #1;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd9 || iss_stall !== 1'b0)
      begin errors++; $display("FAIL same_setup: got wen=%0b rd=%0d stall=%0b exp 1 9 0", gpr_wen, gpr_waddr, iss_stall); end
    tick();
    query(9);
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL same_set_wins: got %0b exp 1", iss_stall); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL same_idle: got %0b exp 0", idle); end
    iss_valid = 0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    claim(1);
    claim(2);
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1111;
    tick();
    alu_valid = 0; lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h2222;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd1) begin errors++; $display("FAIL b2b_first: got wen=%0b rd=%0d exp 1 1", gpr_wen, gpr_waddr); end
    tick();
    lsu_valid = 0;
    checks++; if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd2 || gpr_wdata !== 32'h2222)
      begin errors++; $display("FAIL b2b_second: got wen=%0b rd=%0d d=%h exp 1 2 2222", gpr_wen, gpr_waddr, gpr_wdata); end
    tick();
    checks++; if (idle !== 1'b1 || wb_err !== 1'b0) begin errors++; $display("FAIL b2b_end: got idle=%0b err=%0b exp 1 0", idle, wb_err); end
  endtask

  task automatic test_mid_reset;
    claim(6);
    claim(8);
    lsu_valid = 1; lsu_rd = 13; lsu_data = 32'h13;
    tick();
    lsu_valid = 0; alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    tick();
    checks++; if (gpr_wen !== 1'b1 || wb_err !== 1'b1 || idle !== 1'b0)
      begin errors++; $display("FAIL mid_setup: got wen=%0b err=%0b idle=%0b exp 1 1 0", gpr_wen, wb_err, idle); end
    #2 reset = 1'b0;
    #1;
    checks++; if (gpr_wen !== 1'b0 || idle !== 1'b1 || wb_err !== 1'b0 || gpr_waddr !== 5'd0)
      begin errors++; $display("FAIL mid_async: got wen=%0b idle=%0b err=%0b rd=%0d exp 0 1 0 0", gpr_wen, idle, wb_err, gpr_waddr); end
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (gpr_wen !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL mid_after1: got wen=%0b idle=%0b exp 0 1", gpr_wen, idle); end
    query(8);
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL mid_busy_clear: got %0b exp 0", iss_stall); end
    iss_valid = 0;
    tick();
    checks++; if (gpr_wen !== 1'b0) begin errors++; $display("FAIL mid_after2: got %0b exp 0", gpr_wen); end
  endtask

  initial begin
    test_reset();
    test_claim_write();
    test_hazard();
    test_contention();
    test_err_x0();
    test_same_edge();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish exp finish by 100us");
    $fatal(1);
  end

endmodule

// File: doc/gpr_wb.md
GPR_WB -- requirements
Module: gpr_wb

Interface
REQ-001 SHALL have parameter NR_REG, default 32: number of architectural registers, with index 0 hardwired to zero.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports alu_valid (input, 1), alu_ready (output, 1), alu_rd (input, 5) and alu_data (input, 32): ALU result channel.
REQ-005 SHALL have ports lsu_valid (input, 1), lsu_ready (output, 1), lsu_rd (input, 5) and lsu_data (input, 32): load/store result channel.
REQ-006 SHALL have ports iss_valid (input, 1), iss_rd (input, 5), iss_rs1 (input, 5) and iss_rs2 (input, 5): issue-stage query and destination claim.
REQ-007 SHALL have port iss_stall, output, 1 bit: issue must hold because of a register hazard.
REQ-008 SHALL have ports gpr_wen (output, 1), gpr_waddr (output, 5) and gpr_wdata (output, 32): these drive the register-file write port.
REQ-009 SHALL have port idle, output, 1 bit: no write is pending or in flight.
REQ-010 SHALL have port wb_err, output, 1 bit: sticky flag for a result arriving for a register that is not busy.

Function
REQ-011 SHALL hold a one-entry writeback register (wb_valid, wb_rd, wb_data) that drives gpr_wen, gpr_waddr and gpr_wdata directly from flops.
REQ-012 SHALL drive lsu_ready constant 1, and alu_ready = !lsu_valid, giving fixed priority LSU over ALU.
REQ-013 SHALL treat a transfer as occurring on a channel only when that channel's valid and ready are both high at the clock edge.
REQ-014 SHALL load the writeback register on the edge of a transfer, so gpr_wen asserts exactly 1 cycle after the handshake.
REQ-015 SHALL clear wb_valid on any edge with no transfer; the writeback register never stalls, and back-to-back transfers give back-to-back writes.
REQ-016 SHALL, when a transfer has rd == 0, complete the handshake but leave wb_valid at 0, with no write, no scoreboard change and no wb_err.
REQ-017 SHALL keep a scoreboard busy[NR_REG-1:1]; busy[0] reads as 0 at all times.
REQ-018 SHALL set busy[iss_rd] at an edge when iss_valid & !iss_stall & iss_rd != 0.
REQ-019 SHALL clear busy[wb_rd] at an edge when wb_valid is high, i.e. at the same edge the register file commits the write.
REQ-020 SHALL let the set win when a set and a clear target the same index at the same edge.
REQ-021 SHALL compute iss_stall combinationally as iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]), with index-0 terms forced to 0; there is no bypass.
REQ-022 SHALL assert iss_stall for a register in the cycle its gpr_wen is high, and SHALL deassert it for that register from the next cycle on.
REQ-023 SHALL hold iss_stall at 0 whenever iss_valid is 0.
REQ-024 SHALL set wb_err at an edge where a transfer carries rd != 0 and busy[rd] is 0 (sampled before that edge's updates); the result is still written.
REQ-025 SHALL clear wb_err only by reset.
REQ-026 SHALL drive idle = !wb_valid & (no busy bit set).
REQ-027 SHALL select the LSU transfer when both channels are valid in the same cycle; the ALU channel holds its data because alu_ready is 0.

Reset
REQ-028 SHALL, while reset is low, immediately force wb_valid=0, all busy bits 0 and wb_err=0, independent of clock.
REQ-029 SHALL drive the following outputs during reset: gpr_wen=0, gpr_waddr=0, gpr_wdata=0, idle=1, lsu_ready=1, alu_ready=!lsu_valid, and iss_stall=0 (busy bits clear).
REQ-030 SHALL discard any transfer in flight when reset asserts mid-operation, with no write issued after reset releases.
REQ-031 SHALL resume normal operation on the first rising clock edge after reset deasserts.

Verification
REQ-032 Claim and write: issue rd=5 at cycle 0, ALU transfer rd=5 data=0xDEADBEEF at cycle 3 -> gpr_wen=1, waddr=5, wdata=0xDEADBEEF at cycle 4; busy[5] clear from cycle 5; idle=1 at cycle 5.
REQ-033 Hazard: busy[7]=1 and issue rs1=7 -> iss_stall=1 until the cycle after gpr_wen for rd 7; an issue with rs1=0 and rd=0 never stalls.
REQ-034 Contention: ALU (rd 3, 0x11) and LSU (rd 4, 0x22) both valid at cycle 0 -> alu_ready=0; write rd 4 at cycle 1, write rd 3 at cycle 2.
REQ-035 Same-edge claim: wb_valid with wb_rd=9 while issuing rd=9 -> busy[9] remains 1 after the edge.
REQ-036 Error and x0: LSU transfer rd=12 with busy[12]=0 -> write occurs and wb_err=1, held until reset; transfer rd=0 -> no gpr_wen and wb_err unchanged.
REQ-037 Mid-operation reset: reset asserted with busy bits set and wb_valid=1 -> gpr_wen=0, idle=1 and wb_err=0 immediately, with no write after reset releases.
